spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

- Sequences single SPI frames into the SPI slave from a parallel request port: drives `SS_n` and `MOSI`, samples `MISO` for read-data frames, and returns the read byte on a response pulse.
- Sits between the test/host sequencer and the slave.
- Shares the slave's system clock: all pins change and are sampled on `posedge clk`, not on a derived SCK.

## Interface

Parameters:
- `TURNAROUND`, default 2: cycles between the last command bit and the first `MISO` sample on read-data frames; legal range 1..15.
- `GAP_CYCLES`, default 1: minimum cycles `SS_n` is held high between frames; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both `req_valid` and `req_ready` are high.
- `req_cmd`  in  2  frame command; 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- `req_data`  in  8  frame payload (address or data).
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data` is valid with it.
- `rsp_data`  out  8  byte shifted in from `MISO`.
- `busy`  out  1  high whenever state is not IDLE.
- `SS_n`  out  1  slave select, active low.
- `MOSI`  out  1  serial data to the slave.
- `MISO`  in  1  serial data from the slave.

## Operation

- States: IDLE, SELECT, SHIFT, TURN, READ, GAP. The encoding is free.
- IDLE
  - `req_ready`=1, `SS_n`=1, `MOSI`=0.
  - On accept: latch the 10-bit word {`req_cmd`,`req_data`} into the shift register, then go to SELECT.
- SELECT (1 cycle)
  - `SS_n`=0, `MOSI`=`cmd[1]`. This is the slave's write/read selector bit.
  - Go to SHIFT.
- SHIFT (10 cycles)
  - `SS_n`=0; `MOSI` carries b9..b0, MSB first, one bit per cycle.
  - A 4-bit counter counts 0..9.
  - After b0: go to TURN if cmd==11, else go to GAP.
- TURN (`TURNAROUND` cycles)
  - `SS_n`=0, `MOSI`=0, `MISO` ignored.
  - Go to READ.
- READ (8 cycles)
  - `SS_n`=0, `MOSI`=0.
  - Sample `MISO` each cycle into the rx shift register, MSB first.
  - Go to GAP.
- GAP (`GAP_CYCLES` cycles)
  - `SS_n`=1, `MOSI`=0.
  - Go to IDLE.
- `rsp_valid` pulses for exactly the first GAP cycle after a READ, with `rsp_data` = the 8 sampled bits. `rsp_data` holds its value until the next read completes.
- No backpressure on the response.
- `req_cmd` values 00, 01 and 10 never produce `rsp_valid`.
- `req_valid` outside IDLE is ignored. The request must be held until accepted.
- `req_cmd`/`req_data` changing after accept does not affect the frame in flight.

## Timing

- All outputs are registered.
- Reset values: `SS_n`=1, `MOSI`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `req_ready`=0.
- `req_ready` rises on the first cycle after `rst_n` is sampled high.
- Request accepted at edge T gives:
  - T+1: `SS_n` falls.
  - T+2..T+11: the 10 command/payload bits.
- Write/read-addr frames:
  - `SS_n` rises at T+12.
  - `req_ready` returns at T+12+`GAP_CYCLES`.
  - Back-to-back period is 12+`GAP_CYCLES` cycles (13 at defaults).
- Read-data frames:
  - `MISO` is sampled at T+12+`TURNAROUND` .. T+19+`TURNAROUND`.
  - `rsp_valid` and `SS_n` rise at T+20+`TURNAROUND`.
  - `req_ready` returns at T+20+`TURNAROUND`+`GAP_CYCLES` (T+23 at defaults).
- `SS_n` is never low for fewer than 11 consecutive cycles and never low across two frames.
- `rst_n` low mid-frame: on the next edge `SS_n`=1, state=IDLE, counters cleared, and no `rsp_valid` for the aborted frame. Reset overrides any simultaneous accept.
- `req_valid` high in the same cycle the controller returns to IDLE: the request is accepted at that edge, with no extra bubble.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles while `req_valid`=1 → `SS_n`=1, `MOSI`=0, `req_ready`=0, no frame started; `req_ready`=1 one cycle after release.
- **Write-addr:** `req_cmd`=00, `req_data`=0xA5 → `SS_n` low for 11 cycles, `MOSI` = 0, then 0,0,1,0,1,0,0,1,0,1; `SS_n` high at T+12; `req_ready` at T+13; no `rsp_valid`.
- **Read-data:** `req_cmd`=11, `req_data`=0x00, slave model returns 0x3C on `MISO` → `MOSI` = 1, then 1,1,0,0,0,0,0,0,0,0; `rsp_valid` for one cycle at T+22 with `rsp_data`=0x3C; `SS_n` low T+1..T+21.
- **Back-to-back:** 01/0x55 then 10/0x0F with `req_valid` held high → second `SS_n` fall exactly 13 cycles after the first; `SS_n` high for exactly 1 cycle between frames.
- **Reset mid-frame:** assert `rst_n`=0 during READ bit 4 of a read-data frame → `SS_n`=1 next edge, no `rsp_valid`; a following read-data frame returns correct data.
- **Parameter sweep:** `TURNAROUND`=5, `GAP_CYCLES`=3, read-data with slave returning 0xFF → `rsp_valid` at T+25 with `rsp_data`=0xFF; `req_ready` at T+28.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI frame sequencer: one 10-bit command frame per request,
// optional turnaround and 8-bit MISO read, all on the system clock.
module spi_master_ctrl #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SHIFT,
    S_TURN,
    S_READ,
    S_GAP
  } state_t;

  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [9:0] tx_q;
  logic [9:0] tx_d;
  logic [7:0] rx_q;
  logic [7:0] rx_d;
  logic       rd_q;
  logic       rd_d;
  logic       accept;
  logic       rsp_valid_d;
  logic [7:0] rsp_data_d;
  logic       ss_n_d;
  logic       mosi_d;
  logic       busy_d;
  logic       ready_d;

  assign accept = req_valid && req_ready && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_d    = {req_cmd, req_data};
          rd_d    = (req_cmd == 2'b11);
          cnt_d   = 4'd0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d   = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = rd_q ? S_TURN : S_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
          tx_d  = {tx_q[8:0], 1'b0};
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        rx_d = {rx_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          cnt_d       = 4'd0;
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[6:0], MISO};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pins are registered from the next state so they line up with it.
  always_comb begin
    ss_n_d  = (state_d == S_IDLE) || (state_d == S_GAP);
    mosi_d  = 1'b0;
    if ((state_d == S_SELECT) || (state_d == S_SHIFT)) begin
      mosi_d = tx_d[9];
    end
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      tx_q      <= 10'd0;
      rx_q      <= 8'd0;
      rd_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      SS_n      <= ss_n_d;
      MOSI      <= mosi_d;
      busy      <= busy_d;
      req_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two parameter sets, directed and
// random frames against a cycle-offset reference model.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n     [2];
  logic       req_valid [2];
  logic [1:0] req_cmd   [2];
  logic [7:0] req_data  [2];
  logic       miso      [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       busy      [2];
  logic       ss_n      [2];
  logic       mosi      [2];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fall_cyc [2];
  logic [7:0] last_rsp [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl #(.TURNAROUND(2), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cmd(req_cmd[0]), .req_data(req_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0])
  );

  spi_master_ctrl #(.TURNAROUND(5), .GAP_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cmd(req_cmd[1]), .req_data(req_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1])
  );

  function automatic int ta(int d);
    return (d == 1) ? 5 : 2;
  endfunction

  function automatic int gp(int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [12:0] obs(int d);
    return {ss_n[d], mosi[d], rsp_valid[d], req_ready[d],
            busy[d], rsp_data[d]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Values seen at negedge before edge T+k model what the slave samples
  // at T+k; accept edge is T.
  task automatic frame(input int d, input logic [1:0] cmd,
                       input logic [7:0] data, input logic [7:0] mb,
                       input int abort_k);
    int t;
    int fin;
    int idx;
    logic [9:0] w;
    logic e_ss, e_mosi, e_rv, e_rdy;
    req_valid[d] = 1'b1;
    req_cmd[d]   = cmd;
    req_data[d]  = data;
    t = 0;
    while (req_ready[d] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("d%0d accept_wait", d), 32'(t < 40), 32'd1);
    if (t >= 40) begin
      req_valid[d] = 1'b0;
      return;
    end
    w   = {cmd, data};
    fin = (cmd == 2'b11) ? 20 + ta(d) : 12;
    for (int k = 1; k <= fin + gp(d); k++) begin
      @(negedge clk);
      if (k == 1) begin
        fall_cyc[d]  = cyc;
        req_valid[d] = 1'($urandom_range(0, 1));
        req_cmd[d]   = 2'($urandom);
        req_data[d]  = 8'($urandom);
      end
      e_ss   = (k >= fin);
      e_mosi = 1'b0;
      if (k == 1) e_mosi = cmd[1];
      else if (k <= 11) e_mosi = w[11-k];
      e_rv  = (cmd == 2'b11) && (k == fin);
      e_rdy = (k == fin + gp(d));
      if (e_rv) last_rsp[d] = mb;
      check($sformatf("d%0d c%0d k%0d", d, cmd, k), 32'(obs(d)),
            32'({e_ss, e_mosi, e_rv, e_rdy, !e_rdy, last_rsp[d]}));
      idx = k - 12 - ta(d);
      if (idx >= 0 && idx <= 7) miso[d] = mb[7-idx];
      else miso[d] = 1'($urandom);
      if (k == abort_k) begin
        rst_n[d] = 1'b0;
        @(negedge clk);
        last_rsp[d] = 8'h00;
        check($sformatf("d%0d abort k%0d", d, k), 32'(obs(d)),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        rst_n[d]     = 1'b1;
        req_valid[d] = 1'b0;
        return;
      end
    end
    req_valid[d] = 1'b0;
  endtask

  initial begin
    int f1;
    int n;
    logic [1:0] c;
    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b1;
      req_cmd[d]   = 2'b11;
      req_data[d]  = 8'hFF;
      miso[d]      = 1'b0;
      last_rsp[d]  = 8'h00;
      fall_cyc[d]  = 0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        check($sformatf("d%0d reset%0d", d, i), 32'(obs(d)),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    end
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      rst_n[d]     = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d ready_after_reset", d), 32'(obs(d)),
            32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}));

    frame(0, 2'b00, 8'hA5, 8'h00, 0);
    frame(0, 2'b11, 8'h00, 8'h3C, 0);

    frame(0, 2'b01, 8'h55, 8'h00, 0);
    f1 = fall_cyc[0];
    frame(0, 2'b10, 8'h0F, 8'h00, 0);
    check("b2b_period", 32'(fall_cyc[0] - f1), 32'd13);

    frame(0, 2'b11, 8'h81, 8'hE7, 16 + ta(0));
    frame(0, 2'b11, 8'h42, 8'h96, 0);

    frame(1, 2'b11, 8'h12, 8'hFF, 0);
    frame(1, 2'b00, 8'h34, 8'h00, 0);
    frame(1, 2'b11, 8'h56, 8'h5A, 16 + ta(1));
    frame(1, 2'b11, 8'h78, 8'hC3, 0);

    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom);
      n = (c == 2'b11) ? 20 + ta(i % 2) : 12;
      frame(i % 2, c, 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0) ? $urandom_range(2, n - 1) : 0);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
